// File: rtl/vga_clock_display.sv
// VGA clock back end: 640x480@72 Hz timing from a 31.5 MHz pixel clock and a
// three-stage block-font renderer that draws HH:MM:SS in the top-left corner.
module vga_clock_display #(
  parameter int FONT_W    = 4,
  parameter int FONT_H    = 5,
  parameter int NUM_CHARS = 8
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic [1:0] hrs_d,
  input  logic [3:0] hrs_u,
  input  logic [2:0] min_d,
  input  logic [3:0] min_u,
  input  logic [2:0] sec_d,
  input  logic [3:0] sec_u,
  output logic       hsync,
  output logic       vsync,
  output logic       activevideo,
  output logic       r1,
  output logic       r2,
  output logic       g1,
  output logic       g2,
  output logic       b1,
  output logic       b2
);

  localparam int STAGES = 3;
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd664;
  localparam logic [9:0] H_SYNC_E = 10'd704;
  localparam logic [9:0] H_LAST   = 10'd831;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd489;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST   = 10'd519;
  localparam logic [3:0] CODE_COLON = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;
  localparam logic [5:0] FW6     = 6'(FONT_W);
  localparam logic [5:0] FH6     = 6'(FONT_H);
  localparam logic [5:0] X_LIMIT = 6'(FONT_W * NUM_CHARS);

  // Digit values above 9 have no glyph and render as a blank cell.
  function automatic logic [3:0] digit_code(input logic [3:0] d);
    return (d > 4'd9) ? CODE_BLANK : d;
  endfunction

  // Font rows, top to bottom, MSB is the leftmost column.
  function automatic logic [3:0] font_rom(input logic [5:0] addr);
    logic [3:0] row;
    row = 4'h0;
    case (addr)
      6'd0,  6'd4,  6'd10, 6'd12, 6'd14, 6'd15, 6'd19, 6'd22,
      6'd25, 6'd27, 6'd29, 6'd30, 6'd32, 6'd34, 6'd35, 6'd40,
      6'd42, 6'd44, 6'd45, 6'd47, 6'd49:                row = 4'hF;
      6'd1,  6'd2,  6'd3,  6'd20, 6'd21, 6'd33, 6'd41,
      6'd43, 6'd46:                                     row = 4'h9;
      6'd11, 6'd16, 6'd18, 6'd23, 6'd24, 6'd28, 6'd36,
      6'd48:                                            row = 4'h1;
      6'd5,  6'd7,  6'd8,  6'd37:                       row = 4'h2;
      6'd6,  6'd51, 6'd53:                              row = 4'h6;
      6'd9,  6'd17:                                     row = 4'h7;
      6'd13, 6'd26, 6'd31:                              row = 4'h8;
      6'd38, 6'd39:                                     row = 4'h4;
      default:                                          row = 4'h0;
    endcase
    return row;
  endfunction

  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic [5:0] font_addr_p1_q, font_addr_p1_d;
  logic [1:0] col_p1_q, col_p1_d, col_p2_q, col_p2_d;
  logic [5:0] x_block_p1_q, x_block_p1_d, x_block_p2_q, x_block_p2_d;
  logic       region_p1_q, region_p1_d, region_p2_q, region_p2_d;
  logic       hs_p1_q, hs_p1_d, hs_p2_q, hs_p2_d;
  logic       vs_p1_q, vs_p1_d, vs_p2_q, vs_p2_d;
  logic       vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic [3:0] rom_row_p2_q, rom_row_p2_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
  logic       r1_q, r1_d, r2_q, r2_d, g1_q, g1_d, g2_q, g2_d, b1_q, b1_d, b2_q, b2_d;

  logic [5:0] x_block_c, y_block_c, char_idx_c;
  logic [3:0] code_c;
  logic       region_c, pix_on_c;

  always_comb begin
    hc_d = (hc_q == H_LAST) ? 10'd0 : hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) vc_d = (vc_q == V_LAST) ? 10'd0 : vc_q + 10'd1;

    // S1: block coordinates, character select and font address
    x_block_c  = hc_q[9:4];
    y_block_c  = vc_q[9:4];
    char_idx_c = x_block_c / FW6;
    region_c   = (x_block_c < X_LIMIT) && (y_block_c < FH6);
    code_c     = CODE_BLANK;
    case (char_idx_c)
      6'd0:       code_c = digit_code({2'b00, hrs_d});
      6'd1:       code_c = digit_code(hrs_u);
      6'd2, 6'd5: code_c = CODE_COLON;
      6'd3:       code_c = digit_code({1'b0, min_d});
      6'd4:       code_c = digit_code(min_u);
      6'd6:       code_c = digit_code({1'b0, sec_d});
      6'd7:       code_c = digit_code(sec_u);
      default:    code_c = CODE_BLANK;
    endcase
    font_addr_p1_d = region_c ? ({2'b00, code_c} * FH6 + y_block_c) : 6'd0;
    col_p1_d       = 2'(x_block_c % FW6);
    x_block_p1_d   = x_block_c;
    region_p1_d    = region_c;
    hs_p1_d        = !((hc_q >= H_SYNC_S) && (hc_q < H_SYNC_E));
    vs_p1_d        = !((vc_q >= V_SYNC_S) && (vc_q < V_SYNC_E));
    vld_p1_d       = (hc_q < H_VIS) && (vc_q < V_VIS);

    // S2: font ROM read
    rom_row_p2_d = font_rom(font_addr_p1_q);
    col_p2_d     = col_p1_q;
    x_block_p2_d = x_block_p1_q;
    region_p2_d  = region_p1_q;
    hs_p2_d      = hs_p1_q;
    vs_p2_d      = vs_p1_q;
    vld_p2_d     = vld_p1_q;

    // S3: pixel select, colour ramp and registered outputs
    pix_on_c = vld_p2_q && region_p2_q && rom_row_p2_q[2'd3 - col_p2_q];
    hsync_d  = hs_p2_q;
    vsync_d  = vs_p2_q;
    active_d = vld_p2_q;
    r1_d     = pix_on_c;
    r2_d     = pix_on_c && (x_block_p2_q > 6'd8);
    g1_d     = pix_on_c && (x_block_p2_q > 6'd16);
    g2_d     = pix_on_c && (x_block_p2_q > 6'd20);
    b1_d     = pix_on_c && (x_block_p2_q > 6'd24);
    b2_d     = pix_on_c && (x_block_p2_q > 6'd28);
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      hc_q <= '0;            vc_q <= '0;
      font_addr_p1_q <= '0;  col_p1_q <= '0;  x_block_p1_q <= '0;
      region_p1_q <= 1'b0;   hs_p1_q <= 1'b1; vs_p1_q <= 1'b1; vld_p1_q <= 1'b0;
      rom_row_p2_q <= '0;    col_p2_q <= '0;  x_block_p2_q <= '0;
      region_p2_q <= 1'b0;   hs_p2_q <= 1'b1; vs_p2_q <= 1'b1; vld_p2_q <= 1'b0;
      hsync_q <= 1'b1;       vsync_q <= 1'b1; active_q <= 1'b0;
      r1_q <= 1'b0; r2_q <= 1'b0; g1_q <= 1'b0;
      g2_q <= 1'b0; b1_q <= 1'b0; b2_q <= 1'b0;
    end else begin
      hc_q <= hc_d;          vc_q <= vc_d;
      font_addr_p1_q <= font_addr_p1_d;  col_p1_q <= col_p1_d;
      x_block_p1_q <= x_block_p1_d;      region_p1_q <= region_p1_d;
      hs_p1_q <= hs_p1_d;    vs_p1_q <= vs_p1_d;  vld_p1_q <= vld_p1_d;
      rom_row_p2_q <= rom_row_p2_d;      col_p2_q <= col_p2_d;
      x_block_p2_q <= x_block_p2_d;      region_p2_q <= region_p2_d;
      hs_p2_q <= hs_p2_d;    vs_p2_q <= vs_p2_d;  vld_p2_q <= vld_p2_d;
      hsync_q <= hsync_d;    vsync_q <= vsync_d;  active_q <= active_d;
      r1_q <= r1_d; r2_q <= r2_d; g1_q <= g1_d;
      g2_q <= g2_d; b1_q <= b1_d; b2_q <= b2_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign activevideo = active_q;
  assign r1 = r1_q;
  assign r2 = r2_q;
  assign g1 = g1_q;
  assign g2 = g2_q;
  assign b1 = b1_q;
  assign b2 = b2_q;

  initial assert (STAGES == 3 && FONT_W == 4);

endmodule

// File: tb/tb_vga_clock_display.sv
// Bench for vga_clock_display: pixel-position reference model with a 3-edge
// output latency, directed pixel checks and randomized digit changes.
module tb_vga_clock_display;
  logic       px_clk = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] hrs_d  = '0;
  logic [3:0] hrs_u  = '0;
  logic [2:0] min_d  = '0;
  logic [3:0] min_u  = '0;
  logic [2:0] sec_d  = '0;
  logic [3:0] sec_u  = '0;
  logic hsync, vsync, activevideo, r1, r2, g1, g2, b1, b2;

  vga_clock_display dut (
    .px_clk(px_clk), .reset(reset),
    .hrs_d(hrs_d), .hrs_u(hrs_u), .min_d(min_d), .min_u(min_u),
    .sec_d(sec_d), .sec_u(sec_u),
    .hsync(hsync), .vsync(vsync), .activevideo(activevideo),
    .r1(r1), .r2(r2), .g1(g1), .g2(g2), .b1(b1), .b2(b2)
  );

  always #5 px_clk = ~px_clk;

  localparam logic [8:0] RST_VEC = 9'b110000000;
  localparam int LINE  = 832;
  localparam int FRAME = 832 * 520;

  int tests = 0;
  int fails = 0;
  int pos_m = 0;
  int hist_pos [3] = '{-1, -1, -1};
  logic [19:0] hist_dig [3];
  int exp_pos = -1;
  logic [8:0] exp_vec = RST_VEC;
  wire  [8:0] dut_vec = {hsync, vsync, activevideo, r1, r2, g1, g2, b1, b2};

  // Glyphs as five 4-bit rows, top row in the top nibble.
  bit [19:0] glyph [12] = '{20'hF999F, 20'h26227, 20'hF1F8F, 20'hF171F,
                            20'h99F11, 20'hF8F1F, 20'hF8F9F, 20'hF1244,
                            20'hF9F9F, 20'hF9F1F, 20'h06060, 20'h00000};

  function automatic logic [8:0] model(input int p, input logic [19:0] dg);
    int x, y, xb, yb, ch, code, dv;
    bit hs, vs, act, drw, on;
    if (p < 0) return RST_VEC;
    x = p % LINE;  y = p / LINE;
    xb = x / 16;   yb = y / 16;  ch = xb / 4;
    hs  = !(x >= 664 && x < 704);
    vs  = !(y >= 489 && y <= 491);
    act = (x < 640) && (y < 480);
    case (ch)
      0: dv = int'(dg[19:18]);
      1: dv = int'(dg[17:14]);
      3: dv = int'(dg[13:11]);
      4: dv = int'(dg[10:7]);
      6: dv = int'(dg[6:4]);
      7: dv = int'(dg[3:0]);
      default: dv = 11;
    endcase
    code = (dv > 9) ? 11 : dv;
    if (ch == 2 || ch == 5) code = 10;
    drw = (xb < 32) && (yb < 5) && glyph[code][19 - 4*yb - (xb % 4)];
    on  = act && drw;
    return {hs, vs, act, on, on && xb > 8, on && xb > 16, on && xb > 20,
            on && xb > 24, on && xb > 28};
  endfunction

  task automatic tick();
    @(posedge px_clk);
    if (reset) begin
      for (int i = 0; i < 3; i++) hist_pos[i] = -1;
      pos_m = 0;
    end else begin
      hist_pos[2] = hist_pos[1]; hist_dig[2] = hist_dig[1];
      hist_pos[1] = hist_pos[0]; hist_dig[1] = hist_dig[0];
      hist_pos[0] = pos_m;
      hist_dig[0] = {hrs_d, hrs_u, min_d, min_u, sec_d, sec_u};
      pos_m = (pos_m + 1) % FRAME;
    end
    exp_pos = hist_pos[2];
    exp_vec = model(hist_pos[2], hist_dig[2]);
    #1;
  endtask

  task automatic set_time_105100();
    hrs_d = 2'd1; hrs_u = 4'd0; min_d = 3'd5; min_u = 4'd1; sec_d = 3'd0; sec_u = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) begin
      tick();
      tests++;
      if (dut_vec !== RST_VEC) begin
        fails++;
        $display("FAIL reset_state: got %b expected %b", dut_vec, RST_VEC);
      end
    end
  endtask

  task automatic test_sync_timing();
    int falls [2];
    int nfall = 0, low_cnt = 0;
    logic prev_hs = 1'b1;
    set_time_105100();
    reset = 1'b0;
    for (int n = 1; n <= 2 * LINE + 10; n++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL sync_model n=%0d: got %b expected %b", n, dut_vec, exp_vec);
      end
      if (prev_hs && !hsync && nfall < 2) begin falls[nfall] = n; nfall++; end
      if (n >= 667 && n < 667 + LINE && !hsync) low_cnt++;
      prev_hs = hsync;
      if (exp_pos == 40 || exp_pos == 100 || exp_pos == 10 || exp_pos == 50 || exp_pos == 700) begin
        logic [8:0] want;
        want = (exp_pos == 40 || exp_pos == 100) ? 9'b111100000 :
               (exp_pos == 700) ? 9'b010000000 : 9'b111000000;
        tests++;
        if (dut_vec !== want) begin
          fails++;
          $display("FAIL glyph_line0 x=%0d: got %b expected %b", exp_pos, dut_vec, want);
        end
      end
    end
    tests++;
    if (nfall < 2 || falls[0] != 667 || falls[1] != 667 + LINE) begin
      fails++;
      $display("FAIL hsync_fall: got count %0d first %0d second %0d expected 667 and %0d",
               nfall, falls[0], falls[1], 667 + LINE);
    end
    tests++;
    if (low_cnt != 40) begin
      fails++;
      $display("FAIL hsync_width: got %0d expected 40", low_cnt);
    end
  endtask

  task automatic test_mid_reset();
    int target = 2 * LINE + 300;
    int guard = 0, fall_n = -1, act_cnt = 0;
    logic prev_hs = 1'b1;
    while (pos_m != target && guard < 5000) begin
      tick(); guard++;
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL pre_reset_model: got %b expected %b", dut_vec, exp_vec);
      end
    end
    tests++;
    if (pos_m != target) begin
      fails++;
      $display("FAIL mid_reset_reach: got pos %0d expected %0d", pos_m, target);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (dut_vec !== RST_VEC) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b expected %b", dut_vec, RST_VEC);
    end
    reset = 1'b0;
    for (int n = 1; n <= LINE + 20; n++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL post_reset_model n=%0d: got %b expected %b", n, dut_vec, exp_vec);
      end
      if (prev_hs && !hsync && fall_n < 0) fall_n = n;
      if (n <= LINE && activevideo) act_cnt++;
      prev_hs = hsync;
    end
    tests++;
    if (fall_n != 667) begin
      fails++;
      $display("FAIL restart_hsync_fall: got %0d expected 667", fall_n);
    end
    tests++;
    if (act_cnt != 640) begin
      fails++;
      $display("FAIL active_width: got %0d expected 640", act_cnt);
    end
  endtask

  task automatic test_colon_ramp();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_time_105100();
    while (pos_m < 18 * LINE) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL colon_model pos=%0d: got %b expected %b", exp_pos, dut_vec, exp_vec);
      end
      if (exp_pos == 16 * LINE + 150) begin
        tests++;
        if (dut_vec !== 9'b111110000) begin
          fails++;
          $display("FAIL colon_ramp: got %b expected %b", dut_vec, 9'b111110000);
        end
      end
      if (exp_pos == 470) begin
        tests++;
        if (dut_vec !== 9'b111111111) begin
          fails++;
          $display("FAIL full_ramp: got %b expected %b", dut_vec, 9'b111111111);
        end
      end
    end
  endtask

  task automatic test_random_region();
    while (pos_m < 82 * LINE) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL random_model pos=%0d: got %b expected %b", exp_pos, dut_vec, exp_vec);
      end
      if (exp_pos >= 0 && (exp_pos / LINE >= 80 || exp_pos % LINE >= 512)) begin
        tests++;
        if (dut_vec[5:0] !== 6'b0) begin
          fails++;
          $display("FAIL out_of_region pos=%0d: got %b expected 000000", exp_pos, dut_vec[5:0]);
        end
      end
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 5))
          0: hrs_d = 2'($urandom_range(0, 3));
          1: hrs_u = 4'($urandom_range(0, 15));
          2: min_d = 3'($urandom_range(0, 7));
          3: min_u = 4'($urandom_range(0, 15));
          4: sec_d = 3'($urandom_range(0, 7));
          default: sec_u = 4'($urandom_range(0, 15));
        endcase
      end
    end
  endtask

  task automatic test_blank_digit();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_time_105100();
    sec_u = 4'd12;
    for (int n = 1; n <= 520; n++) begin
      tick();
      tests++;
      if (dut_vec !== exp_vec) begin
        fails++;
        $display("FAIL blank_model pos=%0d: got %b expected %b", exp_pos, dut_vec, exp_vec);
      end
      if (exp_pos == 470) begin
        tests++;
        if (dut_vec !== 9'b111000000) begin
          fails++;
          $display("FAIL blank_digit: got %b expected %b", dut_vec, 9'b111000000);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sync_timing();
    test_mid_reset();
    test_colon_ramp();
    test_random_region();
    test_blank_digit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
